pps_timekeeper: RTL

//  Consumes the 1 Hz square wave from the fractional-divider PPS generator.

---
 rtl/pps_timekeeper.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pps_timekeeper.sv
// pps_timekeeper: PPS edge detector, BCD time-of-day counter, LED stretcher and
// PPS-loss watchdog with a valid/ready time-load port.
// Ports:
//   i_clk, i_reset_n       clock (posedge) and async active-low reset
//   i_pps                  asynchronous 1 Hz square wave
//   i_set_valid/i_set_time load request and BCD {hh,mm,ss} value
//   o_set_ready            load accepted when i_set_valid && o_set_ready
//   o_set_err              1-cycle pulse on a rejected (non-BCD/out-of-range) load
//   o_time                 current BCD {hh,mm,ss}
//   o_tick                 1-cycle pulse per counted second
//   o_led                  stretched tick indicator
//   o_status/o_pps_lost    00 WAIT, 01 LOCKED, 10 LOST; lost flag
module pps_timekeeper #(
  parameter int unsigned CLOCK_RATE_HZ      = 100,
  parameter int unsigned LED_STRETCH_CYCLES = CLOCK_RATE_HZ / 10,
  parameter int unsigned TIMEOUT_CYCLES     = CLOCK_RATE_HZ * 5 / 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pps,
  input  logic        i_set_valid,
  input  logic [23:0] i_set_time,
  output logic        o_set_ready,
  output logic        o_set_err,
  output logic [23:0] o_time,
  output logic        o_tick,
  output logic        o_led,
  output logic [1:0]  o_status,
  output logic        o_pps_lost
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LED_W = $clog2(LED_STRETCH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_LOST   = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, prev_q;
  logic               pps_edge;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [LED_W-1:0]   led_cnt_q, led_cnt_d;
  logic [23:0]        time_d, time_inc;
  logic               tick_d, err_d, led_d, lost_d;
  logic               transfer, load_ok;

  // BCD +1 of a two-digit field; range wrap is handled by the caller.
  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_step = {v[7:4] + 4'd1, 4'd0};
    else                bcd_step = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign pps_edge = sync2_q & ~prev_q;
  assign transfer = i_set_valid & o_set_ready;
  assign o_status = state_q;

  // Load value check: all digits decimal, hh<=23, mm<=59, ss<=59.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i_set_time[i*4 +: 4] > 4'd9) load_ok = 1'b0;
    end
    if (i_set_time[23:16] > 8'h23) load_ok = 1'b0;
    if (i_set_time[15:12] > 4'd5)  load_ok = 1'b0;
    if (i_set_time[7:4]   > 4'd5)  load_ok = 1'b0;
  end

  // One-second BCD increment with ripple carry ss -> mm -> hh.
  always_comb begin
    time_inc = o_time;
    if (o_time[7:0] == 8'h59) begin
      time_inc[7:0] = 8'h00;
      if (o_time[15:8] == 8'h59) begin
        time_inc[15:8]  = 8'h00;
        time_inc[23:16] = (o_time[23:16] == 8'h23) ? 8'h00 : bcd_step(o_time[23:16]);
      end else begin
        time_inc[15:8] = bcd_step(o_time[15:8]);
      end
    end else begin
      time_inc[7:0] = bcd_step(o_time[7:0]);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    time_d    = o_time;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    led_cnt_d = led_cnt_q;
    led_d     = 1'b0;
    lost_d    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        wd_d = '0;
        if (pps_edge) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (pps_edge) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_LOST;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_LOST: begin
        wd_d = '0;
        if (pps_edge) state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
    endcase

    // The alignment edge in WAIT does not count as a second.
    tick_d = pps_edge && (state_q != ST_WAIT);
    err_d  = transfer && !load_ok;

    // A valid load overrides a simultaneous increment.
    if (transfer && load_ok) time_d = i_set_time;
    else if (tick_d)         time_d = time_inc;

    if (tick_d)                  led_cnt_d = LED_W'(LED_STRETCH_CYCLES);
    else if (led_cnt_q != '0)    led_cnt_d = led_cnt_q - LED_W'(1);

    led_d  = (led_cnt_d != '0);
    lost_d = (state_d == ST_LOST);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_WAIT;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      wd_q        <= '0;
      led_cnt_q   <= '0;
      o_time      <= '0;
      o_tick      <= 1'b0;
      o_set_err   <= 1'b0;
      o_set_ready <= 1'b0;
      o_led       <= 1'b0;
      o_pps_lost  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_pps;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      wd_q        <= wd_d;
      led_cnt_q   <= led_cnt_d;
      o_time      <= time_d;
      o_tick      <= tick_d;
      o_set_err   <= err_d;
      o_set_ready <= 1'b1;
      o_led       <= led_d;
      o_pps_lost  <= lost_d;
    end
  end

endmodule
